// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, decode-side output buffer
// and the execute-side redirect. master = fetch stage, slave = its environment.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_raw;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_raw, instr_pc,
        input  imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_raw, instr_pc,
        output imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch.sv
// RV32I fetch stage: one outstanding word request, one-entry output buffer.
// Latency: request->valid is k+1 cycles; buffer full blocks new requests; redirect flushes at the same edge.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic     clock_i,
    input  logic     reset_ni,
    fetch_if.master  fetch_bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] raw_q, raw_d;
    logic [31:0] ipc_q, ipc_d;
    logic        kill_q, kill_d;
    logic [31:0] target;

    assign target = fetch_bus.redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC & 32'hFFFF_FFFC;
            raw_q   <= 32'h0;
            ipc_q   <= 32'h0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            raw_q   <= raw_d;
            ipc_q   <= ipc_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        raw_d   = raw_q;
        ipc_d   = ipc_q;
        kill_d  = kill_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (fetch_bus.redirect) begin
                    pc_d = target;
                end else if (fetch_bus.imem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (fetch_bus.redirect) begin
                    pc_d = target;
                    // A response landing with the redirect settles the owed word, so refetch
                    // immediately instead of waiting for a response that will never come.
                    if (fetch_bus.imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (fetch_bus.imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        raw_d   = fetch_bus.imem_rdata;
                        ipc_d   = pc_q;
                        pc_d    = pc_q + 32'd4;
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (fetch_bus.redirect) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (fetch_bus.instr_ready) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fetch_bus.imem_req    = (state_q == REQ) && !fetch_bus.redirect;
    assign fetch_bus.imem_addr   = pc_q;
    assign fetch_bus.instr_valid = (state_q == FULL);
    assign fetch_bus.instr_raw   = raw_q;
    assign fetch_bus.instr_pc    = ipc_q;
endmodule

// File: tb/tb_fetch.sv
module tb_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_if bus();
    fetch_if bus2();

    fetch #(.RESET_PC(32'h0000_0100)) u_dut  (.clock_i(clk), .reset_ni(rst_n), .fetch_bus(bus));
    fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (.clock_i(clk), .reset_ni(rst_n), .fetch_bus(bus2));

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid); end
        checks++; if (bus.instr_raw !== 32'h0) begin errors++; $display("FAIL rst_raw: got %h want 0", bus.instr_raw); end
        checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", bus.instr_pc); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", bus.imem_req); end
    endtask

    task automatic test_first_fetch();
        @(negedge clk);
        bus.imem_ready = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL first_addr: got %h want 100", bus.imem_addr); end
        @(negedge clk);
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0050_0093;
        #1;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL wait_valid: got %b want 0", bus.instr_valid); end
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", bus.instr_valid); end
        checks++; if (bus.instr_raw !== 32'h0050_0093) begin errors++; $display("FAIL first_raw: got %h want 00500093", bus.instr_raw); end
        checks++; if (bus.instr_pc !== 32'h100) begin errors++; $display("FAIL first_pc: got %h want 100", bus.instr_pc); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++; if (bus.instr_valid !== 1'b1 || bus.instr_raw !== 32'h0050_0093 || bus.instr_pc !== 32'h100) begin
                errors++; $display("FAIL bp_hold: got v=%b raw=%h pc=%h want 1/00500093/100", bus.instr_valid, bus.instr_raw, bus.instr_pc);
            end
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b want 0", bus.imem_req); end
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", bus.instr_valid); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104) begin
            errors++; $display("FAIL bp_next: got req=%b addr=%h want 1/104", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_mem_stall();
        int n_acc;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104) begin
                errors++; $display("FAIL stall_hold: got req=%b addr=%h want 1/104", bus.imem_req, bus.imem_addr);
            end
            @(negedge clk);
            #1;
        end
        n_acc = 0;
        bus.imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.imem_req && bus.imem_ready) n_acc++;
            @(negedge clk);
        end
        checks++; if (n_acc !== 1) begin errors++; $display("FAIL stall_accepts: got %0d want 1", n_acc); end
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00A0_0113;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h104 || bus.instr_raw !== 32'h00A0_0113) begin
            errors++; $display("FAIL stall_resp: got v=%b pc=%h raw=%h want 1/104/00a00113", bus.instr_valid, bus.instr_pc, bus.instr_raw);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        bus.imem_ready = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h108) begin
            errors++; $display("FAIL rw_req: got req=%b addr=%h want 1/108", bus.imem_req, bus.imem_addr);
        end
        @(negedge clk);
        bus.imem_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
        @(negedge clk);
        bus.redirect = 1'b0;
        @(negedge clk);
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped: got %b want 0", bus.instr_valid); end
            @(negedge clk);
            bus.imem_rvalid = 1'b0;
        end
        #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
            errors++; $display("FAIL rw_target: got req=%b addr=%h want 1/200", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_redirect_full();
        bus.imem_ready = 1'b1;
        @(negedge clk);
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0013;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h200) begin
            errors++; $display("FAIL rf_full: got v=%b pc=%h want 1/200", bus.instr_valid, bus.instr_pc);
        end
        bus.redirect = 1'b1; bus.redirect_pc = 32'h203; bus.instr_ready = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rf_req_mask: got %b want 0", bus.imem_req); end
        @(negedge clk);
        bus.redirect = 1'b0; bus.instr_ready = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rf_flush: got %b want 0", bus.instr_valid); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
            errors++; $display("FAIL rf_target: got req=%b addr=%h want 1/200", bus.imem_req, bus.imem_addr);
        end
    endtask

    // Scoreboard: tracks which address must be requested next, the single owed
    // response, whether a redirect has orphaned it, and what the buffer must hold.
    task automatic test_random();
        logic [31:0] exp_pc, buf_pc, mem_addr, prev_addr, rpc;
        logic        bufv, owed, killed, prev_stall, rd, acc, resp;
        int          mem_cnt, n_deliv;
        exp_pc = 32'h200; bufv = 1'b0; owed = 1'b0; killed = 1'b0; prev_stall = 1'b0;
        buf_pc = 32'h0; mem_addr = 32'h0; prev_addr = 32'h0; mem_cnt = 0; n_deliv = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rd  = ($urandom % 8) == 0;
            rpc = $urandom;
            bus.redirect    = rd;
            bus.redirect_pc = rpc;
            bus.imem_ready  = ($urandom % 3) != 0;
            bus.instr_ready = $urandom % 2;
            if (owed && mem_cnt == 1) begin
                bus.imem_rvalid = 1'b1; bus.imem_rdata = word_at(mem_addr);
            end else if (!owed && ($urandom % 10) == 0) begin
                bus.imem_rvalid = 1'b1; bus.imem_rdata = $urandom;
            end else begin
                bus.imem_rvalid = 1'b0;
            end
            #1;
            checks++; if (bus.instr_valid !== bufv) begin errors++; $display("FAIL rnd_valid @%0d: got %b want %b", cyc, bus.instr_valid, bufv); end
            if (bufv) begin
                checks++; if (bus.instr_pc !== buf_pc || bus.instr_raw !== word_at(buf_pc)) begin
                    errors++; $display("FAIL rnd_buf @%0d: got pc=%h raw=%h want %h/%h", cyc, bus.instr_pc, bus.instr_raw, buf_pc, word_at(buf_pc));
                end
            end
            if (bus.imem_req) begin
                checks++; if (owed || bufv || rd) begin
                    errors++; $display("FAIL rnd_req_illegal @%0d: got req=1 want 0 (owed=%b full=%b redirect=%b)", cyc, owed, bufv, rd);
                end
            end
            if (prev_stall && !rd) begin
                checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) begin
                    errors++; $display("FAIL rnd_stall_hold @%0d: got req=%b addr=%h want 1/%h", cyc, bus.imem_req, bus.imem_addr, prev_addr);
                end
            end
            acc  = bus.imem_req && bus.imem_ready;
            resp = bus.imem_rvalid && owed;
            if (acc) begin
                checks++; if (bus.imem_addr !== exp_pc) begin errors++; $display("FAIL rnd_addr @%0d: got %h want %h", cyc, bus.imem_addr, exp_pc); end
            end
            prev_stall = bus.imem_req && !bus.imem_ready;
            prev_addr  = bus.imem_addr;
            if (owed) mem_cnt--;
            if (bufv && bus.instr_ready && !rd) begin bufv = 1'b0; n_deliv++; end
            if (resp) begin
                owed = 1'b0;
                if (!killed && !rd) begin bufv = 1'b1; buf_pc = mem_addr; exp_pc = mem_addr + 32'd4; end
            end
            if (acc) begin owed = 1'b1; killed = 1'b0; mem_addr = bus.imem_addr; mem_cnt = $urandom_range(1, 3); end
            if (rd) begin exp_pc = rpc & 32'hFFFF_FFFC; bufv = 1'b0; if (owed) killed = 1'b1; end
        end
        @(negedge clk);
        bus.redirect = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_ready = 1'b0; bus.instr_ready = 1'b0;
        checks++; if (n_deliv < 50) begin errors++; $display("FAIL rnd_progress: got %0d deliveries want >= 50", n_deliv); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        #1;
        checks++; if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_req: got req=%b addr=%h want 1/fffffffc", bus2.imem_req, bus2.imem_addr);
        end
        bus2.imem_ready = 1'b1;
        @(negedge clk);
        bus2.imem_ready = 1'b0; bus2.imem_rvalid = 1'b1; bus2.imem_rdata = 32'h0000_0013;
        @(negedge clk);
        bus2.imem_rvalid = 1'b0;
        #1;
        checks++; if (bus2.instr_valid !== 1'b1 || bus2.instr_pc !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_pc: got v=%b pc=%h want 1/fffffffc", bus2.instr_valid, bus2.instr_pc);
        end
        bus2.instr_ready = 1'b1;
        @(negedge clk);
        bus2.instr_ready = 1'b0;
        #1;
        checks++; if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_next: got req=%b addr=%h want 1/00000000", bus2.imem_req, bus2.imem_addr);
        end
    endtask

    initial begin
        bus.imem_ready = 1'b0;  bus.imem_rvalid = 1'b0;  bus.imem_rdata = 32'h0;
        bus.instr_ready = 1'b0; bus.redirect = 1'b0;     bus.redirect_pc = 32'h0;
        bus2.imem_ready = 1'b0; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = 32'h0;
        bus2.instr_ready = 1'b0; bus2.redirect = 1'b0;   bus2.redirect_pc = 32'h0;
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_mem_stall();
        test_redirect_wait();
        test_redirect_full();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
